systolic_ctrl: RTL and testbench

Sequencer for the N×N weight-stationary systolic array of 32-bit PEs. Loads one weight row per cycle from the weight buffer and streams activation vectors from the activation buffer into the array's west edge with the per-row diagonal skew. Gates the array-wide `compute` enable and flags when each south-edge column result is valid. Sits between the buffer read ports and the PE grid; the north partial-sum inputs of row 0 are tied to zero outside this block.

---
 rtl/systolic_ctrl_if.sv | 47 ++++
 rtl/systolic_ctrl.sv | 138 +++++++++++++
 tb/tb_systolic_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_if.sv
// Control, status and buffer-port bundle between systolic_ctrl and its surroundings.
// The reuse_weights input exists only when SYSTOLIC_CTRL_WREUSE_EN is defined.
interface systolic_ctrl_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned MW = 8
);
  localparam int unsigned AW = $clog2(N);

  logic              start;
  logic [MW-1:0]     num_vectors;
  logic              busy;
  logic              done;
  logic              weight_rd_en;
  logic [AW-1:0]     weight_rd_addr;
  logic [N-1:0]      weight_en;
  logic              act_rd_en;
  logic [MW-1:0]     act_rd_addr;
  logic [N*32-1:0]   act_rd_data;
  logic [N*32-1:0]   act_west;
  logic              compute;
  logic [N-1:0]      out_col_valid;
`ifdef SYSTOLIC_CTRL_WREUSE_EN
  logic              reuse_weights;

  modport slave (
    input  start, num_vectors, reuse_weights, act_rd_data,
    output busy, done, weight_rd_en, weight_rd_addr, weight_en, act_rd_en, act_rd_addr,
           act_west, compute, out_col_valid
  );
  modport master (
    output start, num_vectors, reuse_weights, act_rd_data,
    input  busy, done, weight_rd_en, weight_rd_addr, weight_en, act_rd_en, act_rd_addr,
           act_west, compute, out_col_valid
  );
`else
  modport slave (
    input  start, num_vectors, act_rd_data,
    output busy, done, weight_rd_en, weight_rd_addr, weight_en, act_rd_en, act_rd_addr,
           act_west, compute, out_col_valid
  );
  modport master (
    output start, num_vectors, act_rd_data,
    input  busy, done, weight_rd_en, weight_rd_addr, weight_en, act_rd_en, act_rd_addr,
           act_west, compute, out_col_valid
  );
`endif
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN weight-stationary systolic array: weight load, skewed activation
// streaming, drain and south-edge valid flags. SYSTOLIC_CTRL_WREUSE_EN enables weight reuse.
module systolic_ctrl #(
  parameter int unsigned N  = 4,
  parameter int unsigned MW = 8
) (
  input logic            clk,
  input logic            rst_n,
  systolic_ctrl_if.slave ctl_io
);
  localparam int unsigned AW   = $clog2(N);
  localparam int unsigned CntW = (MW > $clog2(2 * N)) ? MW : $clog2(2 * N);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [MW-1:0]   num_q, num_d;
  // Bits 0..N-1 gate the skewed lanes, bits N..2N-1 are the south-edge column valids.
  logic [2*N-1:0]  vld_q;
  logic            skip_load;

`ifdef SYSTOLIC_CTRL_WREUSE_EN
  logic loaded_q, loaded_d;
  assign skip_load = ctl_io.reuse_weights & loaded_q;
`else
  assign skip_load = 1'b0;
`endif

  always_comb begin
    state_d                = state_q;
    cnt_d                  = cnt_q;
    num_d                  = num_q;
    ctl_io.busy            = (state_q != StIdle);
    ctl_io.done            = 1'b0;
    ctl_io.weight_rd_en    = 1'b0;
    ctl_io.weight_rd_addr  = '0;
    ctl_io.weight_en       = '0;
    ctl_io.act_rd_en       = 1'b0;
    ctl_io.act_rd_addr     = '0;
    ctl_io.compute         = 1'b0;
`ifdef SYSTOLIC_CTRL_WREUSE_EN
    loaded_d               = loaded_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (ctl_io.start) begin
          num_d = ctl_io.num_vectors;
          cnt_d = '0;
          if (!skip_load)                       state_d = StLoadW;
          else if (ctl_io.num_vectors == '0)    state_d = StDone;
          else                                  state_d = StStream;
        end
      end
      StLoadW: begin
        // Row i is read in step i and latched into the PEs one step later.
        if (cnt_q < CntW'(N)) begin
          ctl_io.weight_rd_en   = 1'b1;
          ctl_io.weight_rd_addr = cnt_q[AW-1:0];
        end
        for (int r = 0; r < N; r++) ctl_io.weight_en[r] = (cnt_q == CntW'(r + 1));
        if (cnt_q == CntW'(N)) begin
          cnt_d   = '0;
          state_d = (num_q == '0) ? StDone : StStream;
`ifdef SYSTOLIC_CTRL_WREUSE_EN
          loaded_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStream: begin
        ctl_io.act_rd_en   = 1'b1;
        ctl_io.act_rd_addr = cnt_q[MW-1:0];
        ctl_io.compute     = 1'b1;
        if (cnt_q == CntW'(num_q) - CntW'(1)) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        ctl_io.compute = 1'b1;
        if (cnt_q == CntW'(2 * N - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        ctl_io.done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      num_q    <= '0;
      vld_q    <= '0;
`ifdef SYSTOLIC_CTRL_WREUSE_EN
      loaded_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      vld_q    <= {vld_q[2*N-2:0], ctl_io.act_rd_en};
`ifdef SYSTOLIC_CTRL_WREUSE_EN
      loaded_q <= loaded_d;
`endif
    end
  end

  assign ctl_io.out_col_valid = vld_q[2*N-1:N];
  assign ctl_io.act_west[31:0] = vld_q[0] ? ctl_io.act_rd_data[31:0] : 32'd0;

  // Lane r is delayed by r registers; bubbles are forced to zero by the valid token.
  for (genvar r = 1; r < N; r++) begin : g_lane
    logic [31:0] pipe_q [r];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < r; s++) pipe_q[s] <= '0;
      end else begin
        pipe_q[0] <= ctl_io.act_rd_data[32*r +: 32];
        for (int s = 1; s < r; s++) pipe_q[s] <= pipe_q[s-1];
      end
    end

    assign ctl_io.act_west[32*r +: 32] = vld_q[r] ? pipe_q[r-1] : 32'd0;
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-cycle vector table for a weight-only job plus
// directed jobs driving a behavioural PE grid whose south outputs are checked.
module tb_systolic_ctrl;
  localparam int unsigned N  = 4;
  localparam int unsigned MW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_ctrl_if #(.N(N), .MW(MW)) ctl ();

  systolic_ctrl #(.N(N), .MW(MW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctl_io (ctl)
  );

  // Buffers (1-cycle read latency) and a behavioural weight-stationary PE grid.
  logic [N*32-1:0] wbuf [N];
  logic [N*32-1:0] abuf [256];
  logic [N*32-1:0] wrd_q;
  logic [31:0] wgt_q [N][N];
  logic [31:0] a_q   [N][N];
  logic [31:0] ps_q  [N][N];
  logic [31:0] ain   [N][N];
  logic [31:0] pin   [N][N];

  always_comb begin
    for (int r = 0; r < N; r++) begin
      ain[r][0] = ctl.act_west[32*r +: 32];
      for (int c = 1; c < N; c++) ain[r][c] = a_q[r][c-1];
    end
    for (int c = 0; c < N; c++) begin
      pin[0][c] = 32'd0;
      for (int r = 1; r < N; r++) pin[r][c] = ps_q[r-1][c];
    end
  end

  always @(posedge clk) begin
    if (ctl.weight_rd_en) wrd_q <= wbuf[ctl.weight_rd_addr];
    if (ctl.act_rd_en) ctl.act_rd_data <= abuf[ctl.act_rd_addr];
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (ctl.weight_en[r]) wgt_q[r][c] <= wrd_q[32*c +: 32];
        if (ctl.compute) begin
          a_q[r][c]  <= ain[r][c];
          ps_q[r][c] <= pin[r][c] + ain[r][c] * wgt_q[r][c];
        end
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  function automatic logic [14:0] out_word();
    return {ctl.busy, ctl.done, ctl.weight_rd_en, ctl.weight_rd_addr, ctl.weight_en,
            ctl.act_rd_en, ctl.compute, ctl.out_col_valid};
  endfunction

  function automatic logic [31:0] exp_col(int c, int v);
    logic [31:0] acc = '0;
    for (int r = 0; r < N; r++) acc += abuf[v][32*r +: 32] * wbuf[r][32*c +: 32];
    return acc;
  endfunction

  // Job monitor
  logic mon_en = 1'b0;
  int   rd0, done_cnt, wrd_cnt, ard_cnt, ard_first, cmp_cnt;
  int   vcnt [N];

  always @(negedge clk) begin
    if (mon_en) begin
      if (ctl.done) done_cnt++;
      if (ctl.weight_rd_en) wrd_cnt++;
      if (ctl.compute) cmp_cnt++;
      if (ctl.act_rd_en) begin
        if (ard_cnt == 0) ard_first = cyc;
        chk("act_rd_addr_seq", ctl.act_rd_addr, ard_cnt);
        ard_cnt++;
      end
      for (int c = 0; c < N; c++) begin
        if (ctl.out_col_valid[c]) begin
          chk($sformatf("col%0d_v%0d_value", c, vcnt[c]), ps_q[N-1][c], exp_col(c, vcnt[c]));
          chk($sformatf("col%0d_v%0d_cycle", c, vcnt[c]), cyc, rd0 + N + 1 + c + vcnt[c]);
          vcnt[c]++;
        end
      end
    end
  end

  task automatic run_job(input int m, input logic reuse, input logic skip, input int kick);
    int s, got_done, n, exp_done;
    @(negedge clk);
    done_cnt = 0; wrd_cnt = 0; ard_cnt = 0; ard_first = -1; cmp_cnt = 0;
    for (int c = 0; c < N; c++) vcnt[c] = 0;
    s = cyc;
    rd0 = skip ? s + 1 : s + N + 2;
    ctl.start = 1'b1;
    ctl.num_vectors = MW'(m);
`ifdef SYSTOLIC_CTRL_WREUSE_EN
    ctl.reuse_weights = reuse;
`else
    if (reuse) $display("note: reuse requested without weight reuse support");
`endif
    mon_en = 1'b1;
    @(negedge clk);
    ctl.start = 1'b0;
    if (kick > 0) begin
      repeat (kick - 1) @(negedge clk);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
    end
    got_done = -1;
    n = 0;
    while (got_done < 0 && n < 2000) begin
      if (ctl.done) got_done = cyc;
      else begin
        @(negedge clk);
        n++;
      end
    end
    exp_done = s + (skip ? 0 : N + 1) + ((m > 0) ? m + 2 * N : 0) + 1;
    chk($sformatf("m%0d_done_seen", m), (got_done >= 0), 1);
    chk($sformatf("m%0d_done_cycle", m), got_done - s, exp_done - s);
    repeat (3) @(negedge clk);
    chk($sformatf("m%0d_done_count", m), done_cnt, 1);
    chk($sformatf("m%0d_weight_reads", m), wrd_cnt, skip ? 0 : N);
    chk($sformatf("m%0d_act_reads", m), ard_cnt, m);
    chk($sformatf("m%0d_compute_cycles", m), cmp_cnt, (m > 0) ? m + 2 * N : 0);
    if (m > 0) chk($sformatf("m%0d_first_read", m), ard_first - s, rd0 - s);
    for (int c = 0; c < N; c++) chk($sformatf("m%0d_col%0d_count", m, c), vcnt[c], m);
    chk($sformatf("m%0d_idle_after", m), out_word(), 0);
    mon_en = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // {busy, done, wrd_en, wrd_addr[1:0], weight_en[3:0], act_rd_en, compute, col_valid[3:0]}
    tbl[0] = '{1'b1, 15'b0_0_0_00_0000_0_0_0000};
    tbl[1] = '{1'b0, 15'b1_0_1_00_0000_0_0_0000};
    tbl[2] = '{1'b0, 15'b1_0_1_01_0001_0_0_0000};
    tbl[3] = '{1'b1, 15'b1_0_1_10_0010_0_0_0000};
    tbl[4] = '{1'b0, 15'b1_0_1_11_0100_0_0_0000};
    tbl[5] = '{1'b0, 15'b1_0_0_00_1000_0_0_0000};
    tbl[6] = '{1'b1, 15'b1_1_0_00_0000_0_0_0000};
    tbl[7] = '{1'b0, 15'b0_0_0_00_0000_0_0_0000};
    tbl[8] = '{1'b0, 15'b0_0_0_00_0000_0_0_0000};

    for (int v = 0; v < 256; v++)
      for (int r = 0; r < N; r++) abuf[v][32*r +: 32] = 32'(v * N + r + 1);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wbuf[r][32*c +: 32] = (r == c) ? 32'd1 : 32'd0;
    ctl.start = 1'b0;
    ctl.num_vectors = '0;
    ctl.act_rd_data = '0;
`ifdef SYSTOLIC_CTRL_WREUSE_EN
    ctl.reuse_weights = 1'b0;
`endif

    repeat (2) @(negedge clk);
    chk("reset_outputs", out_word(), 0);
    chk("reset_act_addr", ctl.act_rd_addr, 0);
    chk("reset_act_west_zero", (ctl.act_west == '0), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // M=0 job cycle by cycle; starts at cycle 3 (busy) and 6 (DONE) must be ignored.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ctl.start = tbl[i].start;
      ctl.num_vectors = '0;
      #1;
      chk($sformatf("m0_cycle%0d", i), out_word(), tbl[i].exp);
    end
    ctl.start = 1'b0;

    // Identity weights, single vector [1,2,3,4].
    run_job(1, 1'b0, 1'b0, 0);

    // W[r][c] = r + c, three back-to-back vectors, start pulsed during DRAIN.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wbuf[r][32*c +: 32] = 32'(r + c);
    run_job(3, 1'b0, 1'b0, 12);

    // Reset asserted in the middle of STREAM.
    @(negedge clk);
    ctl.start = 1'b1;
    ctl.num_vectors = 8'd10;
    @(negedge clk);
    ctl.start = 1'b0;
    n = 0;
    while (!ctl.act_rd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_stream", ctl.act_rd_en, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_now", out_word(), 0);
    chk("abort_act_west_zero", (ctl.act_west == '0), 1);
    @(negedge clk);
    chk("abort_outputs_next", out_word(), 0);
    chk("abort_act_addr", ctl.act_rd_addr, 0);
    rst_n = 1'b1;
    run_job(2, 1'b0, 1'b0, 0);

    // Largest job: addresses run 0..254 with no wrap.
    run_job(255, 1'b0, 1'b0, 0);

`ifdef SYSTOLIC_CTRL_WREUSE_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_job(2, 1'b1, 1'b0, 0);
    run_job(3, 1'b1, 1'b1, 0);
    run_job(0, 1'b1, 1'b1, 0);
    run_job(1, 1'b0, 1'b0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
